// File: rtl/bmf_h_decoder_if.sv
// Stream and configuration bundle between the factor-vector producer,
// the H-matrix decoder and the output consumer.
interface bmf_h_decoder_if #(
  parameter int unsigned K = 4,
  parameter int unsigned M = 5
);
  localparam int unsigned AW = $clog2(M + 1);

  logic          in_valid;
  logic          in_ready;
  logic [K-1:0]  in_k;
  logic          out_valid;
  logic          out_ready;
  logic [M-1:0]  out_po;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [AW-1:0] cfg_addr;
  logic [K-1:0]  cfg_data;

  modport slave (
    input  in_valid, in_k, out_ready, cfg_valid, cfg_addr, cfg_data,
    output in_ready, out_valid, out_po, cfg_ready
  );

  modport master (
    output in_valid, in_k, out_ready, cfg_valid, cfg_addr, cfg_data,
    input  in_ready, out_valid, out_po, cfg_ready
  );
endinterface

// File: rtl/bmf_h_decoder.sv
// Two-stage Boolean-matrix-factorization decoder: expands a K-bit factor
// vector into M outputs through a runtime-loadable H matrix (OR or XOR reduce).
module bmf_h_decoder #(
  parameter int unsigned K  = 4,
  parameter int unsigned M  = 5,
  parameter int unsigned CW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  bmf_h_decoder_if.slave       bus,
  output logic                 busy_o,
  output logic [CW-1:0]        out_cnt_o
);
  localparam int unsigned AW = $clog2(M + 1);

  typedef enum logic [1:0] {RUN, DRAIN, LOAD} state_e;

  state_e                state_q, state_d;
  logic [M-1:0][K-1:0]   h_q, h_d;
  logic                  mode_q, mode_d;
  logic [M-1:0][K-1:0]   terms_q, terms_d;
  logic                  valid_a_q, valid_a_d;
  logic [M-1:0]          po_q, po_d;
  logic                  valid_b_q, valid_b_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  ready_a, ready_b, accept_in;

  // Reset matrix: po0 = 0, po_j = k_{j-1} for as many rows as K allows.
  function automatic logic [M-1:0][K-1:0] default_h();
    logic [M-1:0][K-1:0] h;
    h = '0;
    for (int unsigned j = 1; j < M; j++) begin
      if (j <= K) h[j][j-1] = 1'b1;
    end
    return h;
  endfunction

  assign ready_b      = !valid_b_q | bus.out_ready;
  assign ready_a      = !valid_a_q | ready_b;
  assign bus.in_ready = (state_q == RUN) & ready_a & !rst;
  assign accept_in    = bus.in_valid & bus.in_ready;

  assign bus.out_valid = valid_b_q;
  assign bus.out_po    = po_q;
  assign bus.cfg_ready = (state_q == LOAD);
  assign busy_o        = (state_q != RUN);
  assign out_cnt_o     = cnt_q;

  // Config FSM: H and mode only change once both pipeline stages are empty.
  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    mode_d  = mode_q;
    unique case (state_q)
      RUN: begin
        if (bus.cfg_valid) state_d = DRAIN;
      end
      DRAIN: begin
        if (!bus.cfg_valid)                 state_d = RUN;
        else if (!valid_a_q && !valid_b_q)  state_d = LOAD;
      end
      LOAD: begin
        state_d = RUN;
        if (bus.cfg_valid) begin
          for (int unsigned j = 0; j < M; j++) begin
            if (bus.cfg_addr == AW'(j)) h_d[j] = bus.cfg_data;
          end
          if (bus.cfg_addr == AW'(M)) mode_d = bus.cfg_data[0];
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Datapath: stage A holds the AND terms, stage B holds the reduced outputs.
  always_comb begin
    valid_a_d = valid_a_q;
    terms_d   = terms_q;
    valid_b_d = valid_b_q;
    po_d      = po_q;
    cnt_d     = cnt_q + CW'(valid_b_q & bus.out_ready);

    if (ready_a) valid_a_d = accept_in;
    if (accept_in) begin
      for (int unsigned j = 0; j < M; j++) terms_d[j] = h_q[j] & bus.in_k;
    end

    if (ready_b) begin
      valid_b_d = valid_a_q;
      if (valid_a_q) begin
        for (int unsigned j = 0; j < M; j++) begin
          po_d[j] = mode_q ? ^terms_q[j] : |terms_q[j];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RUN;
      h_q       <= default_h();
      mode_q    <= 1'b0;
      terms_q   <= '0;
      valid_a_q <= 1'b0;
      po_q      <= '0;
      valid_b_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      h_q       <= h_d;
      mode_q    <= mode_d;
      terms_q   <= terms_d;
      valid_a_q <= valid_a_d;
      po_q      <= po_d;
      valid_b_q <= valid_b_d;
      cnt_q     <= cnt_d;
    end
  end
endmodule

// File: tb/tb_bmf_h_decoder.sv
// Self-checking bench for bmf_h_decoder: directed scenarios plus random
// traffic scored against a queue-based model of the decode function.
module tb_bmf_h_decoder;
  localparam int unsigned K  = 4;
  localparam int unsigned M  = 5;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          busy;
  logic [CW-1:0] out_cnt;

  always #5 clk = ~clk;

  bmf_h_decoder_if #(.K(K), .M(M)) bus();

  bmf_h_decoder #(.K(K), .M(M), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .busy_o    (busy),
    .out_cnt_o (out_cnt)
  );

  int           errors = 0;
  int           checks = 0;
  logic [K-1:0] h_m [M];
  logic         mode_m;
  logic [M-1:0] exp_q [$];
  int           exp_cnt;
  bit           acc_in, acc_out, acc_cfg;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference decode: count selected ones; OR = any set, XOR = odd count.
  function automatic logic [M-1:0] decode(input logic [K-1:0] k);
    logic [M-1:0] po;
    int n;
    for (int j = 0; j < M; j++) begin
      n = $countones(h_m[j] & k);
      po[j] = mode_m ? (n % 2 == 1) : (n > 0);
    end
    return po;
  endfunction

  task automatic model_reset();
    mode_m = 1'b0;
    for (int j = 0; j < M; j++) begin
      h_m[j] = '0;
      if (j >= 1 && j <= K) h_m[j][j-1] = 1'b1;
    end
    exp_q.delete();
    exp_cnt = 0;
  endtask

  // Called at a falling edge: score the handshakes of the coming rising edge.
  task automatic cycle();
    #1;
    acc_in  = bus.in_valid  && bus.in_ready;
    acc_out = bus.out_valid && bus.out_ready;
    acc_cfg = bus.cfg_valid && bus.cfg_ready;
    if (bus.out_valid) begin
      chk("out_pending", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) chk("out_po", 32'(bus.out_po), 32'(exp_q[0]));
    end
    if (acc_out && exp_q.size() > 0) begin
      void'(exp_q.pop_front());
      exp_cnt = (exp_cnt + 1) % (1 << CW);
    end
    if (acc_in) exp_q.push_back(decode(bus.in_k));
    if (acc_cfg) begin
      if (bus.cfg_addr < M)       h_m[bus.cfg_addr] = bus.cfg_data;
      else if (bus.cfg_addr == M) mode_m = bus.cfg_data[0];
    end
    @(posedge clk);
    @(negedge clk);
    chk("out_cnt", 32'(out_cnt), 32'(exp_cnt));
  endtask

  task automatic send(input logic [K-1:0] k);
    bus.in_valid = 1'b1;
    bus.in_k     = k;
    for (int i = 0; i < 50; i++) begin
      cycle();
      if (acc_in) break;
    end
    if (!acc_in) chk("send_timeout", 0, 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 50; i++) begin
      if (exp_q.size() == 0) break;
      cycle();
    end
    chk("drain_empty", 32'(exp_q.size()), 0);
  endtask

  task automatic cfg_write(input logic [2:0] addr, input logic [K-1:0] data);
    bus.cfg_valid = 1'b1;
    bus.cfg_addr  = addr;
    bus.cfg_data  = data;
    for (int i = 0; i < 50; i++) begin
      cycle();
      if (acc_cfg) break;
    end
    chk("cfg_ack", 32'(acc_cfg), 1);
    bus.cfg_valid = 1'b0;
  endtask

  logic [K-1:0] items [4];
  int n, base;

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_k      = '0;
    bus.out_ready = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_addr  = '0;
    bus.cfg_data  = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_in_ready",  32'(bus.in_ready), 0);
    chk("rst_cfg_ready", 32'(bus.cfg_ready), 0);
    chk("rst_busy",      32'(busy), 0);
    chk("rst_out_cnt",   32'(out_cnt), 0);
    chk("rst_out_po",    32'(bus.out_po), 0);
    model_reset();
    rst = 1'b0;

    // Default decode and latency
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_k      = 4'b1011;
    cycle();
    chk("t1_accept", 32'(acc_in), 1);
    bus.in_valid = 1'b0;
    chk("t1_not_yet", 32'(bus.out_valid), 0);
    cycle();
    chk("t1_valid", 32'(bus.out_valid), 1);
    chk("t1_po", 32'(bus.out_po), 32'(5'b10110));
    cycle();
    chk("t1_cnt", 32'(out_cnt), 1);
    chk("t1_idle", 32'(bus.out_valid), 0);

    // Back-pressure
    items = '{4'h1, 4'h2, 4'h3, 4'h4};
    n = 0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_k     = items[n];
      cycle();
      if (acc_in) n++;
    end
    chk("bp_accepted", 32'(n), 2);
    chk("bp_in_ready", 32'(bus.in_ready), 0);
    chk("bp_hold_po", 32'(bus.out_po), 32'(5'b00010));
    bus.out_ready = 1'b1;
    for (int i = 0; i < 50 && n < 4; i++) begin
      bus.in_k = items[n];
      cycle();
      if (acc_in) n++;
    end
    bus.in_valid = 1'b0;
    chk("bp_all_sent", 32'(n), 4);
    drain();

    // XOR reconfiguration
    cfg_write(3'(M), 4'b0001);
    chk("xor_busy_clear", 32'(busy), 0);
    cfg_write(3'd4, 4'b1111);
    send(4'b0111);
    cycle();
    chk("xor_po4_one", 32'(bus.out_po[4]), 1);
    drain();
    send(4'b1111);
    cycle();
    chk("xor_po4_zero", 32'(bus.out_po[4]), 0);
    drain();

    // Config request with two vectors in flight
    bus.out_ready = 1'b0;
    send(4'b0011);
    send(4'b0101);
    bus.cfg_valid = 1'b1;
    bus.cfg_addr  = 3'd0;
    bus.cfg_data  = 4'b1001;
    cycle();
    chk("cd_busy", 32'(busy), 1);
    chk("cd_in_ready", 32'(bus.in_ready), 0);
    chk("cd_cfg_ready", 32'(bus.cfg_ready), 0);
    repeat (3) cycle();
    chk("cd_cfg_wait", 32'(bus.cfg_ready), 0);
    chk("cd_out_valid", 32'(bus.out_valid), 1);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      cycle();
      if (acc_cfg) break;
    end
    chk("cd_ack", 32'(acc_cfg), 1);
    chk("cd_old_delivered", 32'(exp_q.size()), 0);
    bus.cfg_valid = 1'b0;
    send(4'b0001);
    cycle();
    chk("cd_new_h", 32'(bus.out_po), 32'(5'b10011));
    drain();

    // Random traffic with occasional config writes
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        bus.out_ready = 1'b1;
        cfg_write(3'($urandom_range(0, 7)), K'($urandom));
      end
      bus.in_valid  = 1'($urandom);
      bus.in_k      = K'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drain();

    // Counter wrap: 17 handshakes on a 4-bit counter
    base = exp_cnt;
    n = 0;
    for (int i = 0; i < 100 && n < 17; i++) begin
      bus.in_valid = 1'b1;
      bus.in_k     = K'($urandom);
      cycle();
      if (acc_in) n++;
    end
    bus.in_valid = 1'b0;
    drain();
    chk("wrap_cnt", 32'(out_cnt), 32'((base + 17) % 16));

    // Asynchronous reset with a stalled output
    bus.out_ready = 1'b0;
    send(4'b0010);
    cycle();
    chk("ar_pre_valid", 32'(bus.out_valid), 1);
    #2 rst = 1'b1;
    #1;
    chk("ar_out_valid", 32'(bus.out_valid), 0);
    chk("ar_out_cnt", 32'(out_cnt), 0);
    chk("ar_in_ready", 32'(bus.in_ready), 0);
    chk("ar_busy", 32'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    bus.out_ready = 1'b1;
    send(4'b0001);
    cycle();
    chk("ar_default_h", 32'(bus.out_po), 32'(5'b00010));
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
